// File: rtl/id_ex_stage_if.sv
// Decode/EX stage bus: decode inputs, register-file port, writeback bypass,
// hazard outputs and the registered ID/EX payload.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = 32
) ();
  // decode-side inputs
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pcplus4_d;
  logic [XLEN-1:0] imm_ext_d;
  logic            reg_write_d;
  logic            mem_write_d;
  logic            alu_src_d;
  logic            branch_d;
  logic            jump_d;
  logic [1:0]      result_src_d;
  logic [2:0]      alu_ctrl_d;

  // register file read port
  logic [4:0]      a1;
  logic [4:0]      a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  // writeback bypass and branch resolution
  logic [4:0]      rd_w;
  logic [XLEN-1:0] result_w;
  logic            reg_write_w;
  logic            pc_src_e;

  // hazard control
  logic            stall_f;
  logic            stall_d;
  logic            flush_d;

  // ID/EX pipeline register
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] imm_ext_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] pcplus4_e;
  logic [4:0]      rs1_e;
  logic [4:0]      rs2_e;
  logic [4:0]      rd_e;
  logic            reg_write_e;
  logic            mem_write_e;
  logic            alu_src_e;
  logic            branch_e;
  logic            jump_e;
  logic [1:0]      result_src_e;
  logic [2:0]      alu_ctrl_e;
  logic            valid_e;
  logic [31:0]     instr_e;

  // performance counters
  logic [31:0]     stall_cnt;
  logic [31:0]     flush_cnt;

  // environment / upstream side
  modport master (
    output instr_d, pc_d, pcplus4_d, imm_ext_d,
    output reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d,
    output result_src_d, alu_ctrl_d,
    output rd1, rd2, rd_w, result_w, reg_write_w, pc_src_e,
    input  a1, a2, stall_f, stall_d, flush_d,
    input  rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e,
    input  rs1_e, rs2_e, rd_e,
    input  reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e,
    input  result_src_e, alu_ctrl_e, valid_e, instr_e,
    input  stall_cnt, flush_cnt
  );

  // id_ex_stage side
  modport slave (
    input  instr_d, pc_d, pcplus4_d, imm_ext_d,
    input  reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d,
    input  result_src_d, alu_ctrl_d,
    input  rd1, rd2, rd_w, result_w, reg_write_w, pc_src_e,
    output a1, a2, stall_f, stall_d, flush_d,
    output rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e,
    output rs1_e, rs2_e, rd_e,
    output reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e,
    output result_src_e, alu_ctrl_e, valid_e, instr_e,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register-file addressing, writeback bypass, load-use
// stall, branch flush. Optional counters enabled by macro PERF_CNT_EN.
module id_ex_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [1:0]  RES_LOAD  = 2'b01;

  typedef struct packed {
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      imm_ext;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pcplus4;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_write;
    logic                 alu_src;
    logic                 branch;
    logic                 jump;
    logic [1:0]           result_src;
    logic [2:0]           alu_ctrl;
    logic                 valid;
    logic [31:0]          instr;
  } ex_reg_t;

  ex_reg_t              r_ex;
  ex_reg_t              w_ex_capture;
  ex_reg_t              w_ex_bubble;

  logic [REG_IDX_W-1:0] w_a1;
  logic [REG_IDX_W-1:0] w_a2;
  logic [REG_IDX_W-1:0] w_rd_d;
  logic [XLEN-1:0]      w_op1;
  logic [XLEN-1:0]      w_op2;
  logic                 w_lw_stall;
  logic                 w_flush_e;

  assign w_a1   = bus.instr_d[19:15];
  assign w_a2   = bus.instr_d[24:20];
  assign w_rd_d = bus.instr_d[11:7];

  // Same-cycle writeback bypass; x0 is never forwarded.
  always_comb begin
    w_op1 = bus.rd1;
    w_op2 = bus.rd2;
    if (bus.reg_write_w && (bus.rd_w != '0) && (bus.rd_w == w_a1)) w_op1 = bus.result_w;
    if (bus.reg_write_w && (bus.rd_w != '0) && (bus.rd_w == w_a2)) w_op2 = bus.result_w;
  end

  // Bubbles carry valid=0 and result_src=0, so they can never raise a stall.
  assign w_lw_stall = r_ex.valid && (r_ex.result_src == RES_LOAD) && (r_ex.rd != '0) &&
                      ((r_ex.rd == w_a1) || (r_ex.rd == w_a2));
  assign w_flush_e  = w_lw_stall || bus.pc_src_e;

  always_comb begin
    w_ex_bubble       = '0;
    w_ex_bubble.instr = NOP_INSTR;
  end

  always_comb begin
    w_ex_capture            = '0;
    w_ex_capture.rd1        = w_op1;
    w_ex_capture.rd2        = w_op2;
    w_ex_capture.imm_ext    = bus.imm_ext_d;
    w_ex_capture.pc         = bus.pc_d;
    w_ex_capture.pcplus4    = bus.pcplus4_d;
    w_ex_capture.rs1        = w_a1;
    w_ex_capture.rs2        = w_a2;
    w_ex_capture.rd         = w_rd_d;
    w_ex_capture.reg_write  = bus.reg_write_d;
    w_ex_capture.mem_write  = bus.mem_write_d;
    w_ex_capture.alu_src    = bus.alu_src_d;
    w_ex_capture.branch     = bus.branch_d;
    w_ex_capture.jump       = bus.jump_d;
    w_ex_capture.result_src = bus.result_src_d;
    w_ex_capture.alu_ctrl   = bus.alu_ctrl_d;
    w_ex_capture.valid      = 1'b1;
    w_ex_capture.instr      = bus.instr_d;
  end

  // ID/EX register: reset and flush both load a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= w_ex_bubble;
    end else if (w_flush_e) begin
      r_ex <= w_ex_bubble;
    end else begin
      r_ex <= w_ex_capture;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Free-running event counters, wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lw_stall)   r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.pc_src_e) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

  assign bus.a1      = w_a1;
  assign bus.a2      = w_a2;
  assign bus.stall_f = w_lw_stall;
  assign bus.stall_d = w_lw_stall;
  assign bus.flush_d = bus.pc_src_e;

  assign bus.rd1_e        = r_ex.rd1;
  assign bus.rd2_e        = r_ex.rd2;
  assign bus.imm_ext_e    = r_ex.imm_ext;
  assign bus.pc_e         = r_ex.pc;
  assign bus.pcplus4_e    = r_ex.pcplus4;
  assign bus.rs1_e        = r_ex.rs1;
  assign bus.rs2_e        = r_ex.rs2;
  assign bus.rd_e         = r_ex.rd;
  assign bus.reg_write_e  = r_ex.reg_write;
  assign bus.mem_write_e  = r_ex.mem_write;
  assign bus.alu_src_e    = r_ex.alu_src;
  assign bus.branch_e     = r_ex.branch;
  assign bus.jump_e       = r_ex.jump;
  assign bus.result_src_e = r_ex.result_src;
  assign bus.alu_ctrl_e   = r_ex.alu_ctrl;
  assign bus.valid_e      = r_ex.valid;
  assign bus.instr_e      = r_ex.instr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, load-use stall,
// bypass, flush, combined stall+flush and reset during a stall.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] I_ADD_3_1_2 = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] I_LW_5      = 32'h0000_A283; // lw  x5,0(x1)
  localparam logic [31:0] I_ADD_6_5_2 = 32'h0022_8333; // add x6,x5,x2
  localparam logic [31:0] I_ADD_8_4_0 = 32'h0002_0433; // add x8,x4,x0
  localparam logic [31:0] I_LW_7      = 32'h0000_A383; // lw  x7,0(x1)
  localparam logic [31:0] I_ADD_9_7_0 = 32'h0003_84B3; // add x9,x7,x0

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();

  id_ex_stage #(.XLEN(XLEN), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2,
                     input logic rw, input logic mw, input logic [1:0] rsrc);
    bus.instr_d      = instr;
    bus.rd1          = r1;
    bus.rd2          = r2;
    bus.reg_write_d  = rw;
    bus.mem_write_d  = mw;
    bus.result_src_d = rsrc;
    bus.alu_src_d    = (rsrc == 2'b01) || mw;
  endtask

  initial begin
    bus.instr_d = I_ADD_3_1_2; bus.pc_d = 32'h100; bus.pcplus4_d = 32'h104;
    bus.imm_ext_d = 32'h0; bus.reg_write_d = 1'b1; bus.mem_write_d = 1'b0;
    bus.alu_src_d = 1'b0; bus.branch_d = 1'b0; bus.jump_d = 1'b0;
    bus.result_src_d = 2'b00; bus.alu_ctrl_d = 3'd0; bus.rd1 = 32'h5; bus.rd2 = 32'h7;
    bus.rd_w = 5'd0; bus.result_w = 32'h0; bus.reg_write_w = 1'b0; bus.pc_src_e = 1'b0;

    // reset
    step(); step();
    chk("rst_valid", 32'(bus.valid_e), 0);
    chk("rst_instr", bus.instr_e, NOP);
    chk("rst_rd1", bus.rd1_e, 0);
    chk("rst_regwr", 32'(bus.reg_write_e), 0);
    chk("rst_stall", 32'(bus.stall_f), 0);
    chk("rst_scnt", bus.stall_cnt, 0);
    rst = 1'b0;

    // add x3,x1,x2 capture
    dec(I_ADD_3_1_2, 32'h5, 32'h7, 1'b1, 1'b0, 2'b00);
    bus.imm_ext_d = 32'hFFFF_FFF0; bus.alu_ctrl_d = 3'd2;
    #1;
    chk("a1", 32'(bus.a1), 1);
    chk("a2", 32'(bus.a2), 2);
    step();
    chk("add_rd1", bus.rd1_e, 5);
    chk("add_rd2", bus.rd2_e, 7);
    chk("add_rd", 32'(bus.rd_e), 3);
    chk("add_rs1", 32'(bus.rs1_e), 1);
    chk("add_regwr", 32'(bus.reg_write_e), 1);
    chk("add_valid", 32'(bus.valid_e), 1);
    chk("add_instr", bus.instr_e, I_ADD_3_1_2);
    chk("add_pc", bus.pc_e, 32'h100);
    chk("add_pc4", bus.pcplus4_e, 32'h104);
    chk("add_imm", bus.imm_ext_e, 32'hFFFF_FFF0);
    chk("add_aluctl", 32'(bus.alu_ctrl_e), 2);
    bus.alu_ctrl_d = 3'd0; bus.imm_ext_d = 32'h0;

    // load-use: lw x5 then add x6,x5,x2
    dec(I_LW_5, 32'h64, 32'h0, 1'b1, 1'b0, 2'b01);
    #1;
    chk("lw_nostall", 32'(bus.stall_f), 0);
    step();
    chk("lw_rsrc", 32'(bus.result_src_e), 1);
    dec(I_ADD_6_5_2, 32'hB, 32'h7, 1'b1, 1'b0, 2'b00);
    #1;
    chk("lu_stall_f", 32'(bus.stall_f), 1);
    chk("lu_stall_d", 32'(bus.stall_d), 1);
    chk("lu_flush_d", 32'(bus.flush_d), 0);
    step();
    chk("lu_bub_valid", 32'(bus.valid_e), 0);
    chk("lu_bub_regwr", 32'(bus.reg_write_e), 0);
    chk("lu_bub_instr", bus.instr_e, NOP);
    chk("lu_stall_clr", 32'(bus.stall_f), 0);
    step();
    chk("lu_add_valid", 32'(bus.valid_e), 1);
    chk("lu_add_rs1", 32'(bus.rs1_e), 5);
    chk("lu_add_rd1", bus.rd1_e, 32'hB);
    chk("lu_scnt", bus.stall_cnt, PERF ? 32'd1 : 32'd0);

    // writeback bypass on x4
    dec(I_ADD_8_4_0, 32'h0, 32'h22, 1'b1, 1'b0, 2'b00);
    bus.reg_write_w = 1'b1; bus.rd_w = 5'd4; bus.result_w = 32'hDEAD_BEEF;
    step();
    chk("byp_rd1", bus.rd1_e, 32'hDEAD_BEEF);
    chk("byp_rd2", bus.rd2_e, 32'h22);
    // rd_w = 0: neither x4 read nor x0 read may be bypassed
    dec(I_ADD_8_4_0, 32'h1234, 32'h55, 1'b1, 1'b0, 2'b00);
    bus.rd_w = 5'd0;
    step();
    chk("nobyp_rd1", bus.rd1_e, 32'h1234);
    chk("nobyp_x0", bus.rd2_e, 32'h55);
    bus.reg_write_w = 1'b0;

    // branch flush of a store in decode
    dec(I_ADD_3_1_2, 32'h5, 32'h7, 1'b0, 1'b1, 2'b00);
    bus.pc_src_e = 1'b1;
    #1;
    chk("fl_flush_d", 32'(bus.flush_d), 1);
    chk("fl_stall_f", 32'(bus.stall_f), 0);
    step();
    bus.pc_src_e = 1'b0;
    chk("fl_valid", 32'(bus.valid_e), 0);
    chk("fl_memwr", 32'(bus.mem_write_e), 0);
    chk("fl_fcnt", bus.flush_cnt, PERF ? 32'd1 : 32'd0);

    // lw x7 in EX, load-use and pc_src_e in the same cycle
    dec(I_LW_7, 32'h64, 32'h0, 1'b1, 1'b0, 2'b01);
    step();
    chk("lw7_valid", 32'(bus.valid_e), 1);
    chk("lw7_rd", 32'(bus.rd_e), 7);
    dec(I_ADD_9_7_0, 32'h1, 32'h0, 1'b1, 1'b0, 2'b00);
    bus.pc_src_e = 1'b1;
    #1;
    chk("both_flush_d", 32'(bus.flush_d), 1);
    chk("both_stall_f", 32'(bus.stall_f), 1);
    step();
    bus.pc_src_e = 1'b0;
    #1;
    chk("both_valid", 32'(bus.valid_e), 0);
    chk("both_stall_clr", 32'(bus.stall_f), 0);
    chk("both_flush_clr", 32'(bus.flush_d), 0);
    chk("both_scnt", bus.stall_cnt, PERF ? 32'd2 : 32'd0);
    chk("both_fcnt", bus.flush_cnt, PERF ? 32'd2 : 32'd0);

    // reset while stalled
    dec(I_LW_5, 32'h64, 32'h0, 1'b1, 1'b0, 2'b01);
    step();
    dec(I_ADD_6_5_2, 32'hB, 32'h7, 1'b1, 1'b0, 2'b00);
    #1;
    chk("rs_stall_pre", 32'(bus.stall_f), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rs_valid", 32'(bus.valid_e), 0);
    chk("rs_stall_f", 32'(bus.stall_f), 0);
    chk("rs_rd", 32'(bus.rd_e), 0);
    chk("rs_scnt", bus.stall_cnt, 0);
    chk("rs_fcnt", bus.flush_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
